// File: rtl/window_perf_select.sv
// Sliding-window min/max performance selector.
// Takes (account, A, T) samples and emits the account with extreme A*T over the last WIN samples.
module window_perf_select #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned WIN   = 5,
    parameter int unsigned MODE  = 0,
    parameter int unsigned CW    = $clog2(WIN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DSIZE-1:0]   in_account,
    input  logic [DSIZE-1:0]   in_A,
    input  logic [DSIZE-1:0]   in_T,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DSIZE-1:0]   out_account,
    output logic [2*DSIZE-1:0] out_perf,
    output logic               out_last,
    output logic [CW-1:0]      fill
);

    localparam int unsigned PW = 2 * DSIZE;
    // Only the newest WIN-1 entries are stored; the incoming sample completes the window.
    localparam int unsigned NE = WIN - 1;

    typedef enum logic {
        S_FILL,
        S_STREAM
    } state_t;

    state_t           state;
    logic [DSIZE-1:0] win_acct [NE];
    logic [PW-1:0]    win_perf [NE];
    logic [NE-1:0]    win_vld;

    logic             accept;
    logic             produce;
    logic [PW-1:0]    new_perf;
    logic [DSIZE-1:0] sel_acct;
    logic [PW-1:0]    sel_perf;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign new_perf = PW'(in_A) * PW'(in_T);
    assign produce  = accept && (state == S_STREAM || fill == CW'(WIN - 1) || in_last);

    // Scan newest to oldest with a strict compare so ties keep the most recent entry.
    always_comb begin
        sel_acct = in_account;
        sel_perf = new_perf;
        for (int i = 0; i < int'(NE); i++) begin
            if (win_vld[i] && ((MODE == 0) ? (win_perf[i] < sel_perf)
                                           : (win_perf[i] > sel_perf))) begin
                sel_acct = win_acct[i];
                sel_perf = win_perf[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FILL;
            fill        <= '0;
            win_vld     <= '0;
            out_valid   <= 1'b0;
            out_account <= '0;
            out_perf    <= '0;
            out_last    <= 1'b0;
            for (int i = 0; i < int'(NE); i++) begin
                win_acct[i] <= '0;
                win_perf[i] <= '0;
            end
        end else begin
            if (accept) begin
                for (int i = 1; i < int'(NE); i++) begin
                    win_acct[i] <= win_acct[i-1];
                    win_perf[i] <= win_perf[i-1];
                    win_vld[i]  <= in_last ? 1'b0 : win_vld[i-1];
                end
                win_acct[0] <= in_account;
                win_perf[0] <= new_perf;
                win_vld[0]  <= !in_last;
                if (in_last) begin
                    // Frame end: next frame starts from an empty window.
                    fill  <= '0;
                    state <= S_FILL;
                end else begin
                    if (fill != CW'(WIN)) begin
                        fill <= fill + CW'(1);
                    end
                    state <= (fill >= CW'(WIN - 1)) ? S_STREAM : S_FILL;
                end
            end

            if (produce) begin
                out_valid   <= 1'b1;
                out_account <= sel_acct;
                out_perf    <= sel_perf;
                out_last    <= in_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window_perf_select.sv
// Bench for window_perf_select: MODE=0 and MODE=1 instances share stimulus,
// checked against a queue-based window model.
module tb_window_perf_select;

    localparam int unsigned DSIZE = 8;
    localparam int unsigned WIN   = 5;

    typedef struct packed {
        logic [7:0]  acct;
        logic [15:0] perf;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_account = '0;
    logic [7:0]  in_A = '0;
    logic [7:0]  in_T = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1;
    logic [7:0]  out_account0, out_account1;
    logic [15:0] out_perf0, out_perf1;
    logic [2:0]  fill0, fill1;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t        win_q[$];
    bit          m_valid = 1'b0;
    bit          m_last  = 1'b0;
    logic [7:0]  m_acct0 = '0, m_acct1 = '0;
    logic [15:0] m_perf0 = '0, m_perf1 = '0;
    bit          last_acc = 1'b0;

    always #5 clk = ~clk;

    window_perf_select #(.DSIZE(DSIZE), .WIN(WIN), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_account(in_account), .in_A(in_A), .in_T(in_T), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .out_account(out_account0),
        .out_perf(out_perf0), .out_last(out_last0), .fill(fill0)
    );

    window_perf_select #(.DSIZE(DSIZE), .WIN(WIN), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_account(in_account), .in_A(in_A), .in_T(in_T), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready), .out_account(out_account1),
        .out_perf(out_perf1), .out_last(out_last1), .fill(fill1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: compare against the model at negedge, advance the model, return at posedge+1.
    task automatic tick();
        bit   exp_ready, acc, prod;
        ent_t e;
        @(negedge clk);
        check("out_valid0", 32'(out_valid0), 32'(m_valid));
        check("out_valid1", 32'(out_valid1), 32'(m_valid));
        check("fill0", 32'(fill0), 32'(win_q.size()));
        check("fill1", 32'(fill1), 32'(win_q.size()));
        if (m_valid) begin
            check("acct0", 32'(out_account0), 32'(m_acct0));
            check("perf0", 32'(out_perf0), 32'(m_perf0));
            check("last0", 32'(out_last0), 32'(m_last));
            check("acct1", 32'(out_account1), 32'(m_acct1));
            check("perf1", 32'(out_perf1), 32'(m_perf1));
            check("last1", 32'(out_last1), 32'(m_last));
        end
        exp_ready = !m_valid || out_ready;
        check("in_ready0", 32'(in_ready0), 32'(exp_ready));
        check("in_ready1", 32'(in_ready1), 32'(exp_ready));

        acc  = in_valid && exp_ready;
        prod = 1'b0;
        if (acc) begin
            e.acct = in_account;
            e.perf = 16'(in_A) * 16'(in_T);
            win_q.push_back(e);
            if (win_q.size() > WIN) void'(win_q.pop_front());
            prod = (win_q.size() == WIN) || in_last;
            if (prod) begin
                // Oldest to newest with <= / >= so the latest of equal values is kept.
                for (int i = 0; i < win_q.size(); i++) begin
                    if (i == 0 || win_q[i].perf <= m_perf0) begin
                        m_acct0 = win_q[i].acct;
                        m_perf0 = win_q[i].perf;
                    end
                    if (i == 0 || win_q[i].perf >= m_perf1) begin
                        m_acct1 = win_q[i].acct;
                        m_perf1 = win_q[i].perf;
                    end
                end
                m_last = in_last;
            end
            if (in_last) win_q.delete();
        end
        if (prod) m_valid = 1'b1;
        else if (out_ready) m_valid = 1'b0;
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int acct, input int a, input int t, input bit last);
        in_valid   = 1'b1;
        in_account = 8'(acct);
        in_A       = 8'(a);
        in_T       = 8'(t);
        in_last    = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic model_clear();
        win_q.delete();
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_acct0 = '0; m_acct1 = '0;
        m_perf0 = '0; m_perf1 = '0;
    endtask

    task automatic reset_mid();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid0), 32'd0);
        check("rst_fill", 32'(fill0), 32'd0);
        check("rst_in_ready", 32'(in_ready0), 32'd1);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2;
        check("reset_valid", 32'(out_valid0), 32'd0);
        check("reset_fill", 32'(fill1), 32'd0);
        check("reset_acct", 32'(out_account0), 32'd0);
        check("reset_perf", 32'(out_perf1), 32'd0);
        check("reset_ready", 32'(in_ready0), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic min/max stream
        send(1, 10, 10, 0); check("s1_none", 32'(out_valid0), 32'd0);
        send(2, 5, 4, 0);   check("s2_none", 32'(out_valid0), 32'd0);
        send(3, 3, 3, 0);   check("s3_none", 32'(out_valid0), 32'd0);
        send(4, 2, 10, 0);  check("s4_none", 32'(out_valid0), 32'd0);
        send(5, 7, 7, 0);
        check("s5_acct0", 32'(out_account0), 32'd3);
        check("s5_perf0", 32'(out_perf0), 32'd9);
        check("s5_fill", 32'(fill0), 32'd5);
        check("s5_acct1", 32'(out_account1), 32'd1);
        check("s5_perf1", 32'(out_perf1), 32'd100);
        send(6, 9, 1, 0);
        check("tie_acct0", 32'(out_account0), 32'd6);
        check("tie_perf0", 32'(out_perf0), 32'd9);
        send(7, 255, 255, 1);
        check("last_acct0", 32'(out_account0), 32'd6);
        check("last_perf0", 32'(out_perf0), 32'd9);
        check("last_flag", 32'(out_last0), 32'd1);
        check("last_fill", 32'(fill0), 32'd0);
        check("last_perf1", 32'(out_perf1), 32'd65025);

        // Partial frame
        send(11, 5, 8, 0);
        send(12, 3, 4, 0); check("part_none", 32'(out_valid0), 32'd0);
        send(13, 5, 6, 1);
        check("part_valid", 32'(out_valid0), 32'd1);
        check("part_acct0", 32'(out_account0), 32'd12);
        check("part_perf0", 32'(out_perf0), 32'd12);
        check("part_last", 32'(out_last0), 32'd1);
        check("part_acct1", 32'(out_account1), 32'd11);

        // Full-width product
        send(1, 10, 10, 0); send(2, 5, 4, 0); send(3, 3, 3, 0);
        send(4, 2, 10, 0);  send(5, 7, 7, 0);
        send(8, 255, 255, 0);
        check("wide_acct1", 32'(out_account1), 32'd8);
        check("wide_perf1", 32'(out_perf1), 32'd65025);
        check("wide_acct0", 32'(out_account0), 32'd3);

        // Backpressure: offered sample must wait
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_account = 8'd9; in_A = 8'd1; in_T = 8'd1; in_last = 1'b0;
        #1;
        check("bp_in_ready", 32'(in_ready0), 32'd0);
        tick();
        tick();
        check("bp_hold_valid", 32'(out_valid0), 32'd1);
        check("bp_hold_acct", 32'(out_account0), 32'd3);
        check("bp_fill", 32'(fill0), 32'd5);
        out_ready = 1'b1;
        tick();
        check("bp_rel_acct", 32'(out_account0), 32'd9);
        check("bp_rel_perf", 32'(out_perf0), 32'd1);
        for (int i = 0; i < 20; i++) begin
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), 1'b0);
        end

        // Reset mid-stream with a pending result
        reset_mid();
        for (int i = 0; i < 4; i++) begin
            send(20 + i, 3, 3, 0);
            check("post_rst_none", 32'(out_valid0), 32'd0);
        end
        send(24, 1, 2, 0);
        check("post_rst_valid", 32'(out_valid0), 32'd1);
        check("post_rst_acct0", 32'(out_account0), 32'd24);

        // Randomized traffic with backpressure and frame ends
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 9) < 6);
            if (!(in_valid && !last_acc)) begin
                in_valid   = ($urandom_range(0, 9) < 7);
                in_account = 8'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    in_A = 8'($urandom_range(0, 7));
                    in_T = 8'($urandom_range(0, 3));
                end else begin
                    in_A = 8'($urandom);
                    in_T = 8'($urandom);
                end
                in_last = ($urandom_range(0, 9) == 0);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/window_perf_select.md
Name: window_perf_select

Overview:
- Single-clock, parametrised successor of the account-performance selector.
- Accepts a stream of (account, A, T) samples and computes performance = A*T for each.
- Keeps a sliding window of the last WIN samples. For every accepted sample once the window is full, emits the account whose performance is the minimum in the window (or the maximum, per MODE).
- Sits downstream of the team's input FIFOs, in the clk domain. Adds valid/ready backpressure, frame termination and a selectable mode, none of which the fixed 5-entry version has.

Parameters:
- DSIZE, 8, width of account, A and T. Performance width is 2*DSIZE.
- WIN, 5, window depth; legal range 2..16.
- MODE, 0, 0 = select minimum performance, 1 = select maximum performance.
- CW, $clog2(WIN+1), width of the fill counter (derived; not to be overridden).

Ports:
- clk  input  1  Single clock; all state is updated on the rising edge.
- rst  input  1  Asynchronous active-high reset.
- in_valid  input  1  Input sample valid.
- in_ready  output  1  Block can accept a sample this cycle.
- in_account  input  DSIZE  Account ID.
- in_A  input  DSIZE  Operand A.
- in_T  input  DSIZE  Operand T.
- in_last  input  1  Last sample of the frame.
- out_valid  output  1  Result valid.
- out_ready  input  1  Downstream accepts the result.
- out_account  output  DSIZE  Selected account.
- out_perf  output  2*DSIZE  Performance of the selected account.
- out_last  output  1  Result belongs to the in_last sample.
- fill  output  CW  Number of valid window entries, 0..WIN.

Behaviour:
- Reset is asynchronous, effective immediately. Every register clears: out_valid=0, out_account=0, out_perf=0, out_last=0, fill=0, all window entries and their valid bits cleared. in_ready=1 after reset.
- A reset asserted mid-frame discards the window and any pending output. No result is emitted for that partial frame.
- Input handshake:
  - A sample is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, combinational from out_ready.
  - Inputs must hold stable while in_valid=1 and in_ready=0.
- Arithmetic:
  - perf = in_A * in_T, unsigned, full 2*DSIZE width, no truncation.
  - All comparisons are unsigned on 2*DSIZE bits.
- Window:
  - On accept, entries shift one place toward oldest. The new (account, perf) enters the newest slot; the oldest entry drops out once fill==WIN.
  - fill increments on accept and saturates at WIN.
- Selection:
  - Computed combinationally over the post-shift window, i.e. the existing newest WIN-1 entries plus the incoming sample. Only valid entries are considered.
  - MODE=0 selects the minimum perf; MODE=1 selects the maximum.
  - Tie rule: the most recently accepted entry wins.
- Output:
  - A result is produced on accept when the post-accept fill==WIN.
  - A result is also produced on an in_last accept with a partial window (fill<WIN); selection then covers only the valid entries.
  - Latency is 1 cycle: out_valid rises on the edge after the accepting cycle.
  - out_valid stays high, with out_account, out_perf and out_last stable, until out_ready=1.
  - If a new result is produced in the same cycle out_ready=1, the output register reloads and out_valid stays high (back-to-back throughput of 1/cycle).
  - If there is no new result and out_ready=1, out_valid drops to 0.
- State machine:
  - FILL: fill<WIN; results only on in_last.
  - STREAM: fill==WIN; a result on every accept.
  - FILL->STREAM when the accept brings fill to WIN.
  - Any state -> FILL on accept of in_last: on the next edge, fill=0 and all valid bits clear. The result for that sample still uses the pre-clear window.
  - in_last while fill==0 (single-sample frame): the result is that sample itself, with out_last=1.
- Idle cycles (in_valid=0) do not change the window or fill.

Test Plan:
- Reset, then WIN=5, MODE=0. Stream (1,10,10),(2,5,4),(3,3,3),(4,2,10),(5,7,7) with out_ready=1 -> no output for samples 1-4; after sample 5, out_account=3, out_perf=9; fill=5.
- Continue with (6,9,1) then (7,255,255,in_last=1) -> window tie at perf 9 gives account 6, perf 9. Sample 7 gives account 6, perf 9, out_last=1. Next cycle fill=0.
- MODE=1, same first five samples -> out_account=1, out_perf=100. Then (8,255,255) -> out_account=8, out_perf=65025 (full-width product, no overflow).
- Backpressure: hold out_ready=0 after the first result -> in_ready=0, out_valid/out_account stay stable, and an offered sample is not accepted. Release out_ready=1 with in_valid=1 -> one transfer per cycle, no loss or duplication over 20 samples.
- Partial frame: 3 samples perfs 40,12,30 with the third flagged in_last -> a single result: account of perf 12, out_last=1.
- Assert rst mid-stream with out_valid=1 -> out_valid=0 and fill=0 immediately. After release, a new frame needs WIN samples before its first non-last result.
